hive_rbus_bridge: RTL
=====================

Name: hive_rbus_bridge

Overview:
- Bus master that converts single processor register requests (valid/ready) into rbus strobe cycles for a bank of register-base slaves.
- Sits directly upstream of the register bank and drives the shared rbus address, write and read lines.
- Captures the OR-combined slave read data a fixed latency after the read strobe and returns it on a valid/ready response channel.
- One transaction in flight at a time; writes produce no response.

Parameters:
DATA_W  32  data width (bits)
ADDR_W  4  rbus address width (bits)
RD_LAT  1  cycles from the rbus_rd_o strobe cycle to valid rbus_rd_data_i; legal range 1..15

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_wr_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_W  request address
req_data_i  in  DATA_W  write data
rsp_valid_o  out  1  read response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_data_o  out  DATA_W  read response data
rbus_addr_o  out  ADDR_W  rbus address (registered)
rbus_wr_o  out  1  rbus write strobe, one-cycle pulse
rbus_rd_o  out  1  rbus read strobe, one-cycle pulse
rbus_wr_data_o  out  DATA_W  rbus write data (registered)
rbus_rd_data_i  in  DATA_W  OR-combined slave read data
busy_o  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate): state IDLE, latency counter 0.
  - rbus_addr_o, rbus_wr_data_o, rsp_data_o = 0.
  - rbus_wr_o, rbus_rd_o, rsp_valid_o, busy_o = 0.
  - req_ready_o = 1.
- States: IDLE, WR, RD, WAIT, RESP. req_ready_o = (state == IDLE), combinational from state only, never from req_valid_i.
- IDLE:
  - On accept, register req_addr_i into rbus_addr_o and req_data_i into rbus_wr_data_o (write data loaded for reads too).
  - Go to WR if req_wr_i=1, else RD.
- WR: rbus_wr_o=1 for exactly this cycle. Next state IDLE.
  - Accept at cycle T: strobe in T+1, req_ready_o high again in T+2.
- RD: rbus_rd_o=1 for exactly this cycle. Load counter with RD_LAT. Next state WAIT.
- WAIT:
  - Decrement counter each cycle.
  - In the cycle where counter==1: capture rbus_rd_data_i into rsp_data_o and go to RESP.
  - Data sampled in cycle T+1+RD_LAT, relative to accept at T.
- RESP:
  - rsp_valid_o=1 and rsp_data_o stable until rsp_ready_i=1; then go to IDLE.
  - With RD_LAT=1 and rsp_ready_i held high: accept T, rd strobe T+1, sample T+2, rsp_valid_o in T+3, req_ready_o in T+4.
- rbus_addr_o is held constant from the strobe cycle through the sample cycle, and afterwards until the next accept. Slaves register their address match, so the address must not change before sampling.
- rbus_wr_data_o changes only on accept.
- rbus_wr_o and rbus_rd_o are never high simultaneously, and never high outside WR/RD.
- An unmapped address reads back 0, because the slave OR combine yields 0. No error is signalled.
- rsp_ready_i is ignored outside RESP. A high rsp_ready_i held before RESP completes the handshake in RESP's first cycle.
- req_* inputs are ignored when req_ready_o=0.
- Reset during any state aborts the transaction: no strobe completes, no response is issued.

Test Plan:
- Write 0xDEADBEEF to addr 3, idle bus -> rbus_wr_o=1 for one cycle at T+1 with rbus_addr_o=3, rbus_wr_data_o=0xDEADBEEF; rbus_rd_o stays 0; no rsp_valid_o; req_ready_o=1 at T+2.
- Read addr 5, slave model returns 0x12345678 one cycle after the strobe (RD_LAT=1), rsp_ready_i=1 -> rbus_rd_o pulse at T+1; rsp_valid_o at T+3 with 0x12345678; rbus_addr_o=5 throughout T+1..T+3.
- Read with rsp_ready_i=0 for 4 cycles -> rsp_valid_o and rsp_data_o held stable, req_ready_o=0; next request accepted only after the handshake.
- RD_LAT=3, slave data valid only in cycle T+4 -> sampled value equals T+4 data, not T+2/T+3 values; rsp_valid_o at T+5.
- Back-to-back write addr 1 then read addr 1 with req_valid_i held high -> second request accepted at T+2; read returns the written value.
- Assert rst_i in the WAIT state -> all strobes and rsp_valid_o go 0 immediately; state IDLE; no response after release; next read completes normally.

Source files
------------

// File: rtl/hive_rbus_bridge.sv
// rtl/hive_rbus_bridge.sv - single-outstanding register request to rbus strobe bridge
//
// Converts one processor register request at a time into an rbus write or
// read strobe cycle. Read data is captured RD_LAT cycles after the read
// strobe and returned on a valid/ready response channel. Writes produce no response.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i / req_ready_o    request handshake (ready only when idle)
//   req_wr_i, req_addr_i,        request kind, address, write data
//   req_data_i
//   rsp_valid_o / rsp_ready_i    read response handshake
//   rsp_data_o                   captured read data
//   rbus_addr_o, rbus_wr_data_o  registered rbus address / write data
//   rbus_wr_o, rbus_rd_o         one-cycle rbus strobes
//   rbus_rd_data_i               OR-combined slave read data
//   busy_o                       transaction in progress
module hive_rbus_bridge #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_wr_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [ADDR_W-1:0] rbus_addr_o,
    output logic              rbus_wr_o,
    output logic              rbus_rd_o,
    output logic [DATA_W-1:0] rbus_wr_data_o,
    input  logic [DATA_W-1:0] rbus_rd_data_i,
    output logic              busy_o
);

    localparam logic [3:0] LAT = 4'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    // Address and write data are only loaded here, so the
                    // slaves see a stable address until the next accept.
                    addr_d  = req_addr_i;
                    wdata_d = req_data_i;
                    state_d = req_wr_i ? S_WR : S_RD;
                end
            end
            S_WR: state_d = S_IDLE;
            S_RD: begin
                cnt_d   = LAT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Counter value 1 marks cycle strobe+RD_LAT, when slave data is valid.
                if (cnt_q == 4'd1) begin
                    rdata_d = rbus_rd_data_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and strobe outputs are decoded from state alone, so the
    // asynchronous reset clears them immediately.
    assign req_ready_o    = (state_q == S_IDLE);
    assign rbus_wr_o      = (state_q == S_WR);
    assign rbus_rd_o      = (state_q == S_RD);
    assign rsp_valid_o    = (state_q == S_RESP);
    assign busy_o         = (state_q != S_IDLE);
    assign rbus_addr_o    = addr_q;
    assign rbus_wr_data_o = wdata_q;
    assign rsp_data_o     = rdata_q;

endmodule
